// File: rtl/ram_access_pkg.sv
// ram_access_pkg
//   Shared types and constants for ram_access_controller and its store
//   merge helper: RISC-V load/store funct3 encodings, controller state
//   encoding and byte/halfword lane widths.
package ram_access_pkg;

   // Load encodings of funct3
   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } load_funct3_e;

   // Store encodings of funct3
   typedef enum logic [2:0] {
      SB = 3'd0,
      SH = 3'd1,
      SW = 3'd2
   } store_funct3_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      MERGE = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

endpackage

// File: rtl/ram_access_controller_if.sv
// ram_access_controller_if
//   Request/response handshake bundle between a load/store initiator and
//   ram_access_controller.
//   master : drives reqValid/reqWrite/reqFunct3/reqAddress/reqData and
//            respReady; observes reqReady and the response.
//   slave  : the controller side (mirror of master).
interface ram_access_controller_if;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddress;
   logic [31:0] reqData;
   logic        respValid;
   logic        respReady;
   logic [31:0] respData;
   logic        respError;

   modport master (
      output reqValid, reqWrite, reqFunct3, reqAddress, reqData, respReady,
      input  reqReady, respValid, respData, respError
   );

   modport slave (
      input  reqValid, reqWrite, reqFunct3, reqAddress, reqData, respReady,
      output reqReady, respValid, respData, respError
   );
endinterface

// File: rtl/ram_access_controller_byte_lane_merge.sv
// byte_lane_merge
//   Combinational store merge: inserts the low byte (SB) or low halfword
//   (SH) of newData into the lane of oldWord selected by byteOffset.
//   Any other funct3 passes newData through as a full word.
//   Ports: oldWord (word read from RAM), newData (store data), funct3,
//          byteOffset (address[1:0]), merged (word to write back).
module byte_lane_merge
   import ram_access_pkg::*;
(
   input  logic [WORD_W-1:0] oldWord,
   input  logic [WORD_W-1:0] newData,
   input  logic [2:0]        funct3,
   input  logic [1:0]        byteOffset,
   output logic [WORD_W-1:0] merged
);

   always_comb begin
      merged = oldWord;
      case (funct3)
         SB:      merged[{byteOffset, 3'b000} +: BYTE_W] = newData[BYTE_W-1:0];
         // Halfword lane is picked by address[1] only; address[0] is either
         // rejected upstream or deliberately ignored.
         SH:      merged[{byteOffset[1], 4'b0000} +: HALF_W] = newData[HALF_W-1:0];
         default: merged = newData;
      endcase
   end

endmodule

// File: rtl/ram_access_controller.sv
// ram_access_controller
//   Owns the write port and read port A of the word-wide data RAM. Accepts
//   one load/store at a time, performs read-modify-write for SB/SH and
//   sign/zero extension for loads, and returns one response per request.
//   Optional macro MISALIGNED_CHECK_EN: when defined, misaligned halfword
//   and word accesses are answered with respError and never touch the RAM.
//   Ports:
//     clock, reset       : clock, asynchronous active-high reset
//     bus (slave)        : request/response handshake
//     ramWriteAddress    : RAM write word address
//     ramDataIn          : RAM write data
//     ramWriteEnable     : RAM write strobe
//     ramReadAddress     : RAM read port A word address
//     ramDataOut         : RAM read port A data (one clock after address)
module ram_access_controller
   import ram_access_pkg::*;
#(
   parameter int RAM_A_WIDTH = 12
) (
   input  logic                   clock,
   input  logic                   reset,
   ram_access_controller_if.slave bus,
   output logic [RAM_A_WIDTH-1:0] ramWriteAddress,
   output logic [WORD_W-1:0]      ramDataIn,
   output logic                   ramWriteEnable,
   output logic [RAM_A_WIDTH-1:0] ramReadAddress,
   input  logic [WORD_W-1:0]      ramDataOut
);

`ifdef MISALIGNED_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   state_e                 state, nextState;
   logic                   capWrite;
   logic [2:0]             capFunct3;
   logic [1:0]             capOffset;
   logic [RAM_A_WIDTH-1:0] capWordAddr;
   logic [WORD_W-1:0]      capData;
   logic [WORD_W-1:0]      mergedWord;
   logic                   reqErr;
   logic                   accept;
   logic                   unused_addr_bits;

   // Byte address bits above the RAM word range are ignored.
   assign unused_addr_bits = ^bus.reqAddress[31:RAM_A_WIDTH+2];

   function automatic logic req_error(logic write, logic [2:0] f3, logic [1:0] off);
      logic illegal;
      logic misaligned;
      illegal    = write ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      // f3[1:0]==1 covers LH/LHU/SH, f3[1:0]==2 covers LW/SW
      misaligned = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
      return illegal || (ALIGN_CHECK && misaligned);
   endfunction

   function automatic logic [WORD_W-1:0] extend_load(logic [WORD_W-1:0] w,
                                                     logic [2:0] f3,
                                                     logic [1:0] off);
      logic signed [BYTE_W-1:0] b;
      logic signed [HALF_W-1:0] h;
      logic [WORD_W-1:0]        r;
      b = w[{off, 3'b000} +: BYTE_W];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         LB:      r = WORD_W'(b);
         LH:      r = WORD_W'(h);
         LW:      r = w;
         LBU:     r = {24'b0, b};
         LHU:     r = {16'b0, h};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign reqErr = req_error(bus.reqWrite, bus.reqFunct3, bus.reqAddress[1:0]);
   assign accept = (state == IDLE) && bus.reqValid;

   byte_lane_merge u_merge (
      .oldWord   (ramDataOut),
      .newData   (capData),
      .funct3    (capFunct3),
      .byteOffset(capOffset),
      .merged    (mergedWord)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState       = state;
      bus.reqReady    = 1'b0;
      bus.respValid   = 1'b0;
      ramWriteEnable  = 1'b0;
      ramDataIn       = '0;
      // The RAM read is synchronous, so the address is presented straight
      // from the request while idle; the word is then valid during READ.
      ramReadAddress  = accept ? bus.reqAddress[RAM_A_WIDTH+1:2] : capWordAddr;
      case (state)
         IDLE: begin
            bus.reqReady = 1'b1;
            if (bus.reqValid) begin
               if (reqErr)                                nextState = DONE;
               else if (bus.reqWrite && bus.reqFunct3 == SW) nextState = WRITE;
               else                                       nextState = READ;
            end
         end
         READ:  nextState = capWrite ? MERGE : DONE;
         MERGE: begin
            ramWriteEnable = 1'b1;
            ramDataIn      = mergedWord;
            nextState      = DONE;
         end
         WRITE: begin
            ramWriteEnable = 1'b1;
            ramDataIn      = capData;
            nextState      = DONE;
         end
         DONE: begin
            bus.respValid = 1'b1;
            if (bus.respReady) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         capWrite      <= 1'b0;
         capFunct3     <= '0;
         capOffset     <= '0;
         capWordAddr   <= '0;
         bus.respData  <= '0;
         bus.respError <= 1'b0;
      end else if (accept) begin
         capWrite      <= bus.reqWrite;
         capFunct3     <= bus.reqFunct3;
         capOffset     <= bus.reqAddress[1:0];
         capWordAddr   <= bus.reqAddress[RAM_A_WIDTH+1:2];
         bus.respError <= reqErr;
         bus.respData  <= '0;
      end else if (state == READ && !capWrite) begin
         bus.respData  <= extend_load(ramDataOut, capFunct3, capOffset);
      end
   end

   always_ff @(posedge clock) begin
      if (accept) capData <= bus.reqData;
   end

   assign ramWriteAddress = capWordAddr;

endmodule
